// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered 8-bit ALU execute stage with valid/ready in and out, iterative restoring divider
module lac_8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);
   logic [7:0] p, g;
   logic [4:0] c_lo, c_hi;
   function automatic logic [4:0] cla4(input logic [3:0] pp, input logic [3:0] gg, input logic ci);
      logic [4:0] c;
      c[0] = ci;
      c[1] = gg[0] | (pp[0] & ci);
      c[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
      c[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (&pp[2:0] & ci);
      c[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (&pp[3:1] & gg[0]) | (&pp & ci);
      return c;
   endfunction
   assign p    = a ^ b;
   assign g    = a & b;
   assign c_lo = cla4(p[3:0], g[3:0], cin);
   assign c_hi = cla4(p[7:4], g[7:4], c_lo[4]);
   assign sum  = p ^ {c_hi[3:0], c_lo[3:0]};
   assign cout = c_hi[4];
endmodule

module mul_8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] prod
);
   always_comb begin
      prod = '0;
      for (int i = 0; i < 8; i++)
         prod = prod + ({8{b[i]}} & (a << i));
   end
endmodule

module compare_8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [1:0] code
);
   logic [7:0] diff;
   assign diff = a + ~b + 8'd1;
   assign code = (a == b) ? 2'b00 : diff[7] ? 2'b01 : 2'b10;
endmodule

module alu_exec_stage #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] remainder,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             flag_dz,
   output logic             flag_ill
);
   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
   state_t state, state_nxt;
   logic             accept, div_start, div_last;
   logic [WIDTH-1:0] add_sum, sub_sum, mul_p;
   logic             add_c, sub_c;
   logic [1:0]       cmp_code;
   logic [WIDTH-1:0] op_res, op_rem;
   logic             op_c, op_dz, op_ill;
   logic [WIDTH-1:0] dvd, divisor, rem_acc, rem_new, q_nxt;
   logic [WIDTH:0]   rem_sh, rem_diff;
   logic [CNT_W-1:0] cnt;
   logic             q_bit;

   lac_8     u_add (.a(a), .b(b),  .cin(1'b0), .sum(add_sum), .cout(add_c));
   lac_8     u_sub (.a(a), .b(~b), .cin(1'b1), .sum(sub_sum), .cout(sub_c));
   mul_8     u_mul (.a(a), .b(b), .prod(mul_p));
   compare_8 u_cmp (.a(a), .b(b), .code(cmp_code));

   assign accept    = in_valid & in_ready;
   assign div_start = accept && op == 3'd3 && b != '0;
   assign div_last  = state == DIV && cnt == CNT_W'(WIDTH - 1);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;

   always_comb begin
      state_nxt = state;
      if (accept)
         state_nxt = div_start ? DIV : DONE;
      else if (div_last)
         state_nxt = DONE;
      else if (state == DONE && out_ready)
         state_nxt = IDLE;
   end

   always_comb begin
      in_ready  = state == IDLE || (state == DONE && out_ready);
      out_valid = state == DONE;
   end

   always_comb begin
      op_res = '0;
      op_rem = '0;
      op_c   = 1'b0;
      op_dz  = 1'b0;
      op_ill = 1'b0;
      case (op)
         3'd0: begin op_res = add_sum; op_c = add_c; end
         3'd1: begin op_res = sub_sum; op_c = sub_c; end
         3'd2: op_res = mul_p;
         // only reached with b == 0; nonzero divisors go through the iterative path
         3'd3: begin op_res = '1; op_rem = a; op_dz = 1'b1; end
         3'd4: op_res = {{(WIDTH-2){1'b0}}, cmp_code};
         default: op_ill = 1'b1;
      endcase
   end

   // one extra bit keeps the shifted remainder exact when the divisor exceeds 2**(WIDTH-1)
   always_comb begin
      rem_sh   = {rem_acc, dvd[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, divisor};
      q_bit    = rem_sh >= {1'b0, divisor};
      rem_new  = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      q_nxt    = {dvd[WIDTH-2:0], q_bit};
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         dvd       <= '0;
         divisor   <= '0;
         rem_acc   <= '0;
         cnt       <= '0;
         result    <= '0;
         remainder <= '0;
         flag_z    <= 1'b0;
         flag_n    <= 1'b0;
         flag_c    <= 1'b0;
         flag_dz   <= 1'b0;
         flag_ill  <= 1'b0;
      end else if (div_start) begin
         dvd     <= a;
         divisor <= b;
         rem_acc <= '0;
         cnt     <= '0;
      end else if (accept) begin
         result    <= op_res;
         remainder <= op_rem;
         flag_z    <= op_res == '0;
         flag_n    <= op_res[WIDTH-1];
         flag_c    <= op_c;
         flag_dz   <= op_dz;
         flag_ill  <= op_ill;
      end else if (state == DIV) begin
         dvd     <= q_nxt;
         rem_acc <= rem_new;
         cnt     <= cnt + 1'b1;
         if (div_last) begin
            result    <= q_nxt;
            remainder <= rem_new;
            flag_z    <= q_nxt == '0;
            flag_n    <= q_nxt[WIDTH-1];
            flag_c    <= 1'b0;
            flag_dz   <= 1'b0;
            flag_ill  <= 1'b0;
         end
      end
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: randomized and directed checks of alu_exec_stage against an arithmetic reference model
module tb_alu_exec_stage;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0, out_ready = 1'b0;
   logic       in_ready, out_valid;
   logic [2:0] op = '0;
   logic [7:0] a = '0, b = '0;
   logic [7:0] result, remainder;
   logic       flag_z, flag_n, flag_c, flag_dz, flag_ill;
   logic [20:0] dut_pack;
   int checks = 0, passed = 0;

   alu_exec_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .remainder(remainder),
      .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_dz(flag_dz), .flag_ill(flag_ill)
   );

   always #5 clk = ~clk;
   assign dut_pack = {result, remainder, flag_z, flag_n, flag_c, flag_dz, flag_ill};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
      else passed++;
   endtask

   // packed as {result, remainder, z, n, c, dz, ill}
   function automatic logic [20:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
      int r = 0, rm = 0, c = 0, dz = 0, ill = 0, xi = x, yi = y;
      case (o)
         3'd0: begin r = (xi + yi) % 256; c = (xi + yi) > 255; end
         3'd1: begin r = (xi - yi + 256) % 256; c = xi >= yi; end
         3'd2: r = (xi * yi) % 256;
         3'd3: if (yi == 0) begin r = 255; rm = xi; dz = 1; end else begin r = xi / yi; rm = xi % yi; end
         3'd4: r = (xi == yi) ? 0 : (((xi - yi) & 128) != 0) ? 1 : 2;
         default: ill = 1;
      endcase
      return {r[7:0], rm[7:0], r == 0, r[7], c[0], dz[0], ill[0]};
   endfunction

   task automatic do_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input int hold);
      logic [20:0] e;
      int lat, exp_lat;
      e = model(o, x, y);
      exp_lat = (o == 3'd3 && y != 0) ? 9 : 1;
      @(negedge clk);
      in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b0;
      chk("idle_in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
      lat = 1;
      while (!out_valid && lat < 20) begin
         chk("busy_in_ready", in_ready, 0);
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, exp_lat);
      chk("outputs", dut_pack, e);
      repeat (hold) begin
         @(posedge clk); #1;
         chk("hold_outputs", dut_pack, e);
         chk("hold_valid", out_valid, 1);
         chk("hold_in_ready", in_ready, 0);
      end
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      chk("drain_valid", out_valid, 0);
   endtask

   initial begin
      logic [2:0] o;
      logic [7:0] x, y;
      logic       saw;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_outputs", dut_pack, 0);
      @(negedge clk); rst_n = 1'b1;

      do_op(3'd0, 8'hF0, 8'h20, 0);
      chk("t1_result", result, 8'h10);
      chk("t1_flag_c", flag_c, 1);
      do_op(3'd1, 8'h05, 8'h07, 0);
      chk("t2_result", result, 8'hFE);
      chk("t2_flags_nc", {flag_n, flag_c}, 2'b10);
      do_op(3'd4, 8'h03, 8'h03, 0);
      chk("t2_cmp_z", {result, flag_z}, {8'h00, 1'b1});
      do_op(3'd2, 8'h0C, 8'h0B, 0);
      chk("t3_result", {result, flag_n}, {8'h84, 1'b1});
      do_op(3'd3, 8'hC8, 8'h07, 3);
      chk("t4_div", {result, remainder}, {8'h1C, 8'h04});
      do_op(3'd3, 8'h2A, 8'h00, 0);
      chk("t5_dz", {result, remainder, flag_dz}, {8'hFF, 8'h2A, 1'b1});
      do_op(3'd6, 8'h12, 8'h34, 0);
      chk("t5_ill", {result, flag_ill, flag_z}, {8'h00, 1'b1, 1'b1});
      do_op(3'd3, 8'hFF, 8'hFF, 0);
      do_op(3'd3, 8'hFE, 8'h81, 0);
      do_op(3'd3, 8'h00, 8'h05, 1);

      // back-to-back single-cycle ops with out_ready held high
      @(negedge clk); out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         o = (i == 0) ? 3'd2 : 3'($urandom_range(0, 7));
         x = (i == 0) ? 8'h0C : 8'($urandom);
         y = (i == 0) ? 8'h0B : 8'($urandom);
         if (o == 3'd3) y = 8'h00;
         chk("b2b_in_ready", in_ready, 1);
         in_valid = 1'b1; op = o; a = x; b = y;
         @(posedge clk); #1;
         chk("b2b_valid", out_valid, 1);
         chk("b2b_outputs", dut_pack, model(o, x, y));
         @(negedge clk);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("b2b_drain", out_valid, 0);
      @(negedge clk); out_ready = 1'b0;

      repeat (40) begin
         o = 3'($urandom_range(0, 7));
         x = 8'($urandom);
         y = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         do_op(o, x, y, $urandom_range(0, 2));
      end

      // reset in the middle of a divide
      @(negedge clk); in_valid = 1'b1; op = 3'd3; a = 8'hC8; b = 8'h07;
      @(posedge clk); #1; in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_outputs", dut_pack, 0);
      @(negedge clk); rst_n = 1'b1;
      saw = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         saw |= out_valid;
      end
      chk("no_stale_valid", saw, 0);
      do_op(3'd0, 8'h01, 8'h01, 0);
      chk("t6_result", result, 8'h02);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
